// File: rtl/branch_cmp_seq_pkg.sv
// Shared types and funct3 decode for the multi-cycle branch comparator.
package branch_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Returns {taken, illegal}; 010/011 are not branches.
    function automatic logic [1:0] br_taken_f(input logic [2:0] funct3,
                                              input logic eq, input logic lt);
        logic [1:0] r;
        case (funct3)
            F3_BEQ:           r = {eq, 1'b0};
            F3_BNE:           r = {!eq, 1'b0};
            F3_BLT, F3_BLTU:  r = {lt, 1'b0};
            F3_BGE, F3_BGEU:  r = {!lt, 1'b0};
            default:          r = 2'b01;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_cmp_seq_chunk_cmp.sv
// Unsigned equality / less-than for one CHUNK_W slice of the operands.
module chunk_cmp #(
    parameter int CHUNK_W = 8
) (
    input  logic [CHUNK_W-1:0] a,
    input  logic [CHUNK_W-1:0] b,
    output logic               eq,
    output logic               lt
);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

// File: rtl/branch_cmp_seq.sv
// Multi-cycle branch comparator: scans CHUNK_W bits per cycle from the MSB
// chunk down, stopping at the first differing chunk.
module branch_cmp_seq
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CHUNK_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      funct3_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            br_eq,
    output logic            br_lt,
    output logic            br_taken,
    output logic            illegal
);
    localparam int NCHUNK = XLEN / CHUNK_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (CHUNK_W < 1 || (XLEN % CHUNK_W) != 0) begin : g_bad_cfg
        $error("branch_cmp_seq: XLEN must be a multiple of CHUNK_W");
    end

    state_t                           state, state_d;
    logic [NCHUNK-1:0][CHUNK_W-1:0]   a_q, b_q;
    logic [2:0]                       f3_q;
    logic [IDX_W-1:0]                 idx;
    logic [NCHUNK-1:0]                ch_eq, ch_lt;
    logic [NCHUNK-1:0]                scan_eq, scan_lt;
    logic                             accept, finish, idx_inc, fin_eq, fin_lt;
    logic [XLEN-1:0]                  sign_flip;

    // One comparator per chunk; scan_* reorders them so idx 0 is the MSB chunk.
    for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
        chunk_cmp #(.CHUNK_W(CHUNK_W)) u_cmp (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .eq (ch_eq[i]),
            .lt (ch_lt[i])
        );
        assign scan_eq[i] = ch_eq[NCHUNK-1-i];
        assign scan_lt[i] = ch_lt[NCHUNK-1-i];
    end

    // Signed compare becomes unsigned once both sign bits are inverted.
    assign sign_flip = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        finish  = 1'b0;
        idx_inc = 1'b0;
        fin_eq  = 1'b0;
        fin_lt  = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    accept  = 1'b1;
                    state_d = SCAN;
                end
                SCAN: begin
                    if (!scan_eq[idx]) begin
                        finish = 1'b1;
                        fin_lt = scan_lt[idx];
                    end else if (idx == IDX_W'(NCHUNK-1)) begin
                        finish = 1'b1;
                        fin_eq = 1'b1;
                    end else begin
                        idx_inc = 1'b1;
                    end
                    if (finish) state_d = DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            idx      <= '0;
            br_eq    <= 1'b0;
            br_lt    <= 1'b0;
            br_taken <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            if (accept) begin
                a_q  <= a_i ^ sign_flip;
                b_q  <= b_i ^ sign_flip;
                f3_q <= funct3_i;
                idx  <= '0;
            end
            if (idx_inc) idx <= idx + 1'b1;
            if (finish) begin
                br_eq               <= fin_eq;
                br_lt               <= fin_lt;
                {br_taken, illegal} <= br_taken_f(f3_q, fin_eq, fin_lt);
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp_seq.sv
// Drives three comparator widths (CHUNK_W 8/4/32) in lockstep against an
// arithmetic reference model of compare result and scan latency.
module tb_branch_cmp_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0, b = '0;
    logic [2:0]  f3 = '0;
    logic        in_ready_w[3], out_valid_w[3], eq_w[3], lt_w[3], taken_w[3], ill_w[3];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        branch_cmp_seq #(.XLEN(32), .CHUNK_W(g == 0 ? 8 : (g == 1 ? 4 : 32))) u_dut (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(in_valid), .in_ready(in_ready_w[g]),
            .a_i(a), .b_i(b), .funct3_i(f3),
            .out_valid(out_valid_w[g]), .out_ready(out_ready),
            .br_eq(eq_w[g]), .br_lt(lt_w[g]), .br_taken(taken_w[g]), .illegal(ill_w[g])
        );
    end

    function automatic int cw_of(input int g);
        return (g == 0) ? 8 : ((g == 1) ? 4 : 32);
    endfunction

    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y, input int cw);
        logic [31:0] d;
        d = x ^ y;
        if (d == 0) return 32 / cw;
        for (int i = 31; i >= 0; i--)
            if (d[i]) return (31 - i) / cw + 1;
        return 0;
    endfunction

    function automatic logic exp_lt(input logic [31:0] x, input logic [31:0] y, input logic [2:0] fn);
        if (fn[1]) return x < y;
        return $signed(x) < $signed(y);
    endfunction

    function automatic logic exp_taken(input logic [2:0] fn, input logic e, input logic l);
        case (fn)
            3'b000: return e;
            3'b001: return !e;
            3'b100, 3'b110: return l;
            3'b101, 3'b111: return !l;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_in_ready_cw%0d", tag, cw_of(g)), 32'(in_ready_w[g]), 1);
            chk($sformatf("%s_out_valid_cw%0d", tag, cw_of(g)), 32'(out_valid_w[g]), 0);
            chk($sformatf("%s_outs_cw%0d", tag, cw_of(g)),
                {28'd0, eq_w[g], lt_w[g], taken_w[g], ill_w[g]}, 0);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            if (in_ready_w[0] && in_ready_w[1] && in_ready_w[2]) break;
            tick();
        end
        chk("idle_wait", 32'(in_ready_w[0] && in_ready_w[1] && in_ready_w[2]), 1);
    endtask

    task automatic accept(input logic [31:0] x, input logic [31:0] y, input logic [2:0] fn);
        wait_idle();
        a = x; b = y; f3 = fn; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // One request with out_ready high; checks latency and all flags per width.
    task automatic run_txn(input logic [31:0] x, input logic [31:0] y, input logic [2:0] fn);
        int   lat[3];
        logic ce[3], cl[3], ct[3], ci[3];
        logic e, l;
        out_ready = 1'b1;
        accept(x, y, fn);
        for (int g = 0; g < 3; g++) begin
            lat[g] = 0; ce[g] = 0; cl[g] = 0; ct[g] = 0; ci[g] = 0;
        end
        for (int c = 1; c <= 12; c++) begin
            tick();
            for (int g = 0; g < 3; g++)
                if (lat[g] == 0 && out_valid_w[g]) begin
                    lat[g] = c; ce[g] = eq_w[g]; cl[g] = lt_w[g];
                    ct[g] = taken_w[g]; ci[g] = ill_w[g];
                end
        end
        e = (x == y);
        l = exp_lt(x, y, fn);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("lat_cw%0d a=%h b=%h", cw_of(g), x, y), lat[g], exp_lat(x, y, cw_of(g)));
            chk($sformatf("eq_cw%0d a=%h b=%h", cw_of(g), x, y), 32'(ce[g]), 32'(e));
            chk($sformatf("lt_cw%0d a=%h b=%h f3=%0d", cw_of(g), x, y, fn), 32'(cl[g]), 32'(l));
            chk($sformatf("taken_cw%0d a=%h b=%h f3=%0d", cw_of(g), x, y, fn), 32'(ct[g]),
                32'(exp_taken(fn, e, l)));
            chk($sformatf("illegal_cw%0d f3=%0d", cw_of(g), fn), 32'(ci[g]),
                32'(fn == 3'b010 || fn == 3'b011));
        end
    endtask

    initial begin
        logic [31:0] x, y;
        #2;
        chk_reset_vals("reset");
        tick();
        rst_n = 1'b1;
        tick();

        run_txn(32'h1234_5678, 32'h1234_5678, 3'b000);
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 3'b100);
        run_txn(32'hFFFF_FFFF, 32'h0000_0001, 3'b110);
        run_txn(32'h0000_0010, 32'h0000_0011, 3'b111);
        run_txn(32'h0000_0005, 32'h5000_0000, 3'b010);
        run_txn(32'h8000_0000, 32'h8000_0000, 3'b011);
        run_txn(32'h7FFF_FFFF, 32'h8000_0000, 3'b101);

        // Backpressure: result held, new requests ignored until out_ready.
        out_ready = 1'b0;
        accept(32'h1234_5678, 32'h1234_5678, 3'b000);
        for (int i = 0; i < 9; i++) tick();
        a = 32'h0; b = 32'h1; f3 = 3'b001; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("bp_out_valid_cw%0d", cw_of(g)), 32'(out_valid_w[g]), 1);
                chk($sformatf("bp_in_ready_cw%0d", cw_of(g)), 32'(in_ready_w[g]), 0);
                chk($sformatf("bp_flags_cw%0d", cw_of(g)),
                    {28'd0, eq_w[g], lt_w[g], taken_w[g], ill_w[g]}, 32'b1010);
            end
        end
        out_ready = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("bp_release_valid_cw%0d", cw_of(g)), 32'(out_valid_w[g]), 0);
            chk($sformatf("bp_release_ready_cw%0d", cw_of(g)), 32'(in_ready_w[g]), 1);
        end
        tick();
        in_valid = 1'b0;
        for (int g = 0; g < 3; g++)
            chk($sformatf("bp_reaccept_cw%0d", cw_of(g)), 32'(in_ready_w[g]), 0);
        for (int i = 0; i < 10; i++) tick();

        // Flush in the second SCAN cycle; the CHUNK_W=32 result gets discarded.
        out_ready = 1'b0;
        accept(32'hCAFE_F00D, 32'hCAFE_F00D, 3'b000);
        tick();
        chk("fl_pre_valid_cw8", 32'(out_valid_w[0]), 0);
        chk("fl_pre_valid_cw32", 32'(out_valid_w[2]), 1);
        flush = 1'b1;
        tick();
        flush = 1'b1; in_valid = 1'b1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("fl_valid_cw%0d", cw_of(g)), 32'(out_valid_w[g]), 0);
            chk($sformatf("fl_ready_cw%0d", cw_of(g)), 32'(in_ready_w[g]), 1);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        for (int g = 0; g < 3; g++)
            chk($sformatf("fl_noaccept_cw%0d", cw_of(g)), 32'(in_ready_w[g]), 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("fl_quiet", 32'(out_valid_w[0] | out_valid_w[1] | out_valid_w[2]), 0);
        end

        // Async reset with CHUNK_W=32 holding a result and the others mid-scan.
        accept(32'h0000_0001, 32'h0000_0002, 3'b110);
        tick();
        chk("rst_pre_valid_cw32", 32'(out_valid_w[2]), 1);
        chk("rst_pre_lt_cw32", 32'(lt_w[2] & taken_w[2]), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();

        for (int n = 0; n < 40; n++) begin
            x = $urandom;
            case (n % 4)
                0: y = $urandom;
                1: y = x;
                2: y = x ^ (32'h1 << $urandom_range(0, 31));
                default: y = x ^ (32'hFFFF_FFFF >> $urandom_range(0, 31));
            endcase
            run_txn(x, y, 3'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
